// File: rtl/traffic_light_guard.sv
// rtl/traffic_light_guard.sv - safety monitor between the 4-way light controller and the lamp drivers
// Passes legal light values through one register stage; latches the first violation and flashes red.
module traffic_light_guard #(
    parameter int MIN_GREEN    = 3,
    parameter int MIN_YELLOW   = 2,
    parameter int MAX_RED      = 64,
    parameter int FLASH_PERIOD = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] north,
    input  logic [2:0] east,
    input  logic [2:0] south,
    input  logic [2:0] west,
    input  logic       fault_clr,
    output logic [2:0] north_out,
    output logic [2:0] east_out,
    output logic [2:0] south_out,
    output logic [2:0] west_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic [7:0] fault_count
);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam int         FW     = $clog2(2 * FLASH_PERIOD);

    localparam logic [2:0] C_NONE     = 3'd0;
    localparam logic [2:0] C_ENCODING = 3'd1;
    localparam logic [2:0] C_CONFLICT = 3'd2;
    localparam logic [2:0] C_SEQUENCE = 3'd3;
    localparam logic [2:0] C_SHORT_G  = 3'd4;
    localparam logic [2:0] C_SHORT_Y  = 3'd5;
    localparam logic [2:0] C_STARVE   = 3'd6;

    typedef enum logic {
        PASS     = 1'b0,
        FAILSAFE = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0][2:0]            lights;
    logic [3:0][2:0]            prev_q, prev_d;
    logic [3:0][CNT_W-1:0]      dwell_q, dwell_d;
    logic [3:0][2:0]            out_q, out_d;
    logic                       valid_q, valid_d;
    logic [FW-1:0]              flash_q, flash_d;
    logic [2:0]                 code_q, code_d;
    logic [1:0]                 dir_q, dir_d;
    logic [7:0]                 count_q, count_d;

    logic                       eff_valid;
    logic [3:0]                 onehot;
    logic [3:0]                 nonred;
    logic [3:0]                 changed;
    logic [3:0][2:0]            dcode;
    logic [2:0]                 viol_code;
    logic [1:0]                 viol_dir;
    logic [2:0]                 best;
    logic                       violation;

    // Index 0..3 = N, E, S, W so loops that run downward leave N with the highest priority.
    assign lights = {west, south, east, north};

    always_comb begin
        // A successful clear makes this very sample the new baseline, so history checks are masked.
        eff_valid = valid_q && !(state_q == FAILSAFE && fault_clr);
        onehot    = '0;
        nonred    = '0;
        changed   = '0;
        dcode     = '0;
        for (int d = 0; d < 4; d++) begin
            onehot[d]  = (lights[d] == GREEN) || (lights[d] == YELLOW) || (lights[d] == RED);
            nonred[d]  = (lights[d] != RED);
            changed[d] = (lights[d] != prev_q[d]);
            if (changed[d]) begin
                if (prev_q[d] == GREEN && lights[d] == YELLOW) begin
                    dcode[d] = (dwell_q[d] < CNT_W'(MIN_GREEN)) ? C_SHORT_G : C_NONE;
                end else if (prev_q[d] == YELLOW && lights[d] == RED) begin
                    dcode[d] = (dwell_q[d] < CNT_W'(MIN_YELLOW)) ? C_SHORT_Y : C_NONE;
                end else if (!(prev_q[d] == RED && lights[d] == GREEN)) begin
                    dcode[d] = C_SEQUENCE;
                end
            end else if (lights[d] == RED && dwell_q[d] == CNT_W'(MAX_RED)) begin
                dcode[d] = C_STARVE;
            end
        end

        viol_code = C_NONE;
        viol_dir  = 2'd0;
        best      = 3'd7;
        for (int d = 3; d >= 0; d--) begin
            if (!onehot[d]) begin
                viol_code = C_ENCODING;
                viol_dir  = 2'(d);
            end
        end
        if (viol_code == C_NONE && (nonred[0] || nonred[2]) && (nonred[1] || nonred[3])) begin
            viol_code = C_CONFLICT;
            for (int d = 3; d >= 0; d--) begin
                if (nonred[d]) begin
                    viol_dir = 2'(d);
                end
            end
        end
        if (viol_code == C_NONE && eff_valid) begin
            for (int d = 3; d >= 0; d--) begin
                if (dcode[d] != C_NONE && dcode[d] <= best) begin
                    best     = dcode[d];
                    viol_dir = 2'(d);
                end
            end
            if (best != 3'd7) begin
                viol_code = best;
            end else begin
                viol_dir = 2'd0;
            end
        end
        violation = (viol_code != C_NONE);
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        flash_d = flash_q;
        code_d  = code_q;
        dir_d   = dir_q;
        valid_d = 1'b1;
        prev_d  = lights;
        dwell_d = dwell_q;
        count_d = count_q;

        for (int d = 0; d < 4; d++) begin
            if (!eff_valid || changed[d]) begin
                dwell_d[d] = CNT_W'(1);
            end else if (!(&dwell_q[d])) begin
                dwell_d[d] = dwell_q[d] + CNT_W'(1);
            end
        end

        if (violation && count_q != 8'hff) begin
            count_d = count_q + 8'd1;
        end

        case (state_q)
            PASS: begin
                if (violation) begin
                    state_d = FAILSAFE;
                    code_d  = viol_code;
                    dir_d   = viol_dir;
                    out_d   = {4{RED}};
                    flash_d = FW'(1);
                end else begin
                    out_d = lights;
                end
            end
            FAILSAFE: begin
                if (fault_clr && !violation) begin
                    state_d = PASS;
                    code_d  = C_NONE;
                    dir_d   = 2'd0;
                    out_d   = lights;
                end else begin
                    out_d   = (flash_q < FW'(FLASH_PERIOD)) ? {4{RED}} : '0;
                    flash_d = (flash_q == FW'(2 * FLASH_PERIOD - 1)) ? '0 : flash_q + FW'(1);
                end
            end
            default: begin
                state_d = PASS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PASS;
            out_q   <= {4{RED}};
            prev_q  <= {4{RED}};
            dwell_q <= '0;
            valid_q <= 1'b0;
            flash_q <= '0;
            code_q  <= C_NONE;
            dir_q   <= 2'd0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            prev_q  <= prev_d;
            dwell_q <= dwell_d;
            valid_q <= valid_d;
            flash_q <= flash_d;
            code_q  <= code_d;
            dir_q   <= dir_d;
            count_q <= count_d;
        end
    end

    assign north_out   = out_q[0];
    assign east_out    = out_q[1];
    assign south_out   = out_q[2];
    assign west_out    = out_q[3];
    assign fault       = (state_q == FAILSAFE);
    assign fault_code  = code_q;
    assign fault_dir   = dir_q;
    assign fault_count = count_q;

endmodule

// File: tb/tb_traffic_light_guard.sv
// tb/tb_traffic_light_guard.sv - directed and randomized bench for traffic_light_guard
// Compares every cycle against a cycle-level model of the guard's rules.
module tb_traffic_light_guard;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam int MAX_RED = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fault_clr = 1'b0;
    logic [2:0] north = R, east = R, south = R, west = R;
    logic [2:0] north_out, east_out, south_out, west_out;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_dir;
    logic [7:0] fault_count;

    int total = 0;
    int bad = 0;

    int m_in[4];
    int m_prev[4];
    int m_dwell[4];
    int m_out[4];
    bit m_valid, m_fail;
    int m_code, m_dir, m_count, m_flash_t;

    traffic_light_guard dut (
        .clk(clk), .reset(reset),
        .north(north), .east(east), .south(south), .west(west),
        .fault_clr(fault_clr),
        .north_out(north_out), .east_out(east_out), .south_out(south_out), .west_out(west_out),
        .fault(fault), .fault_code(fault_code), .fault_dir(fault_dir), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    function automatic bit is_onehot(int v);
        return (v == 1) || (v == 2) || (v == 4);
    endfunction

    function automatic int rule(int d);
        int p = m_prev[d];
        int c = m_in[d];
        if (p == c) return (c == 4 && m_dwell[d] == MAX_RED) ? 6 : 0;
        if (p == 1 && c == 2) return (m_dwell[d] < 3) ? 4 : 0;
        if (p == 2 && c == 4) return (m_dwell[d] < 2) ? 5 : 0;
        if (p == 4 && c == 1) return 0;
        return 3;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_out[d] = 4; m_dwell[d] = 0; m_prev[d] = 4;
        end
        m_valid = 0; m_fail = 0; m_code = 0; m_dir = 0; m_count = 0; m_flash_t = 0;
    endtask

    task automatic model_step(input bit clr);
        bit ev;
        int code, dir;
        ev = m_valid && !(m_fail && clr);
        code = 0; dir = 0;
        for (int d = 0; d < 4; d++)
            if (code == 0 && !is_onehot(m_in[d])) begin code = 1; dir = d; end
        if (code == 0 && (m_in[0] != 4 || m_in[2] != 4) && (m_in[1] != 4 || m_in[3] != 4)) begin
            code = 2;
            for (int d = 3; d >= 0; d--) if (m_in[d] != 4) dir = d;
        end
        if (code == 0 && ev) begin
            for (int d = 0; d < 4; d++) begin
                int c = rule(d);
                if (c != 0 && (code == 0 || c < code)) begin code = c; dir = d; end
            end
        end
        if (code != 0 && m_count < 255) m_count++;
        for (int d = 0; d < 4; d++) begin
            if (!ev || m_in[d] != m_prev[d]) m_dwell[d] = 1;
            else if (m_dwell[d] < 255) m_dwell[d]++;
            m_prev[d] = m_in[d];
        end
        m_valid = 1;
        if (!m_fail) begin
            if (code != 0) begin
                m_fail = 1; m_code = code; m_dir = dir; m_flash_t = 0;
                for (int d = 0; d < 4; d++) m_out[d] = 4;
            end else begin
                for (int d = 0; d < 4; d++) m_out[d] = m_in[d];
            end
        end else if (clr && code == 0) begin
            m_fail = 0; m_code = 0; m_dir = 0;
            for (int d = 0; d < 4; d++) m_out[d] = m_in[d];
        end else begin
            m_flash_t++;
            for (int d = 0; d < 4; d++) m_out[d] = ((m_flash_t % 8) < 4) ? 4 : 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [31:0] eo;
        eo = 32'((m_out[3] << 9) | (m_out[2] << 6) | (m_out[1] << 3) | m_out[0]);
        chk("lights_out", 32'({west_out, south_out, east_out, north_out}), eo);
        chk("fault", 32'(fault), 32'(m_fail));
        chk("fault_code", 32'(fault_code), 32'(m_code));
        chk("fault_dir", 32'(fault_dir), 32'(m_dir));
        chk("fault_count", 32'(fault_count), 32'(m_count));
    endtask

    task automatic cyc(input logic [2:0] n, input logic [2:0] e, input logic [2:0] s,
                       input logic [2:0] w, input logic clr);
        north = n; east = e; south = s; west = w; fault_clr = clr;
        @(posedge clk);
        m_in[0] = int'(n); m_in[1] = int'(e); m_in[2] = int'(s); m_in[3] = int'(w);
        model_step(clr);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; north = R; east = R; south = R; west = R; fault_clr = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    task automatic rand_run(input int n);
        int ph = 0, left = 1;
        logic [2:0] l[4];
        for (int i = 0; i < n; i++) begin
            left--;
            if (left <= 0) begin
                ph = (ph + 1) % 6;
                case (ph)
                    0, 3: left = $urandom_range(2, 6);
                    1, 4: left = $urandom_range(1, 3);
                    default: left = 1;
                endcase
            end
            for (int d = 0; d < 4; d++) l[d] = R;
            if (ph == 0 || ph == 1) begin l[0] = (ph == 0) ? G : Y; l[2] = l[0]; end
            if (ph == 3 || ph == 4) begin l[1] = (ph == 3) ? G : Y; l[3] = l[1]; end
            if ($urandom_range(0, 99) < 3) l[$urandom_range(0, 3)] = 3'($urandom_range(0, 7));
            cyc(l[0], l[1], l[2], l[3], m_fail && ($urandom_range(0, 9) == 0));
        end
    endtask

    initial begin
        // Reset state and a legal N/S then E/W cycle.
        do_reset();
        cyc(R, R, R, R, 0);
        repeat (3) cyc(G, R, G, R, 0);
        repeat (2) cyc(Y, R, Y, R, 0);
        cyc(R, R, R, R, 0);
        repeat (3) cyc(R, G, R, G, 0);
        repeat (2) cyc(R, Y, R, Y, 0);
        cyc(R, R, R, R, 0);
        chk("t1_count", 32'(fault_count), 32'd0);

        // Encoding fault, then the flash pattern, then a clear.
        cyc(3'b011, R, R, R, 0);
        chk("t2_code", 32'(fault_code), 32'd1);
        chk("t2_dir", 32'(fault_dir), 32'd0);
        repeat (9) cyc(R, R, R, R, 0);
        cyc(R, R, R, R, 1);
        chk("t2_cleared", 32'(fault), 32'd0);

        // Conflict from a fresh reset.
        do_reset();
        cyc(R, R, R, R, 0);
        cyc(G, G, R, R, 0);
        chk("t3_code", 32'(fault_code), 32'd2);
        chk("t3_dir", 32'(fault_dir), 32'd0);
        chk("t3_count", 32'(fault_count), 32'd1);
        chk("t3_out", 32'({west_out, south_out, east_out, north_out}), 32'h924);
        cyc(R, R, R, R, 1);

        // Short green on East, then an illegal G->R on South.
        repeat (2) cyc(R, G, R, R, 0);
        cyc(R, Y, R, R, 0);
        chk("t4_code_g", 32'(fault_code), 32'd4);
        chk("t4_dir_g", 32'(fault_dir), 32'd1);
        cyc(R, R, R, R, 0);
        cyc(R, R, R, R, 1);
        repeat (3) cyc(R, R, G, R, 0);
        cyc(R, R, R, R, 0);
        chk("t4_code_seq", 32'(fault_code), 32'd3);
        chk("t4_dir_seq", 32'(fault_dir), 32'd2);

        // West starvation while N/S keep cycling.
        do_reset();
        repeat (3) cyc(R, G, R, R, 0);
        repeat (2) cyc(R, Y, R, R, 0);
        cyc(R, R, R, R, 0);
        for (int k = 0; k < 10; k++) begin
            if (k == 9) chk("t5_not_yet", 32'(fault), 32'd0);
            repeat (3) cyc(G, R, G, R, 0);
            repeat (2) cyc(Y, R, Y, R, 0);
            cyc(R, R, R, R, 0);
        end
        chk("t5_code", 32'(fault_code), 32'd6);
        chk("t5_dir", 32'(fault_dir), 32'd3);

        // Clear with legal inputs, clear blocked by a conflict, reset mid-flash.
        cyc(G, R, G, R, 1);
        chk("t6_clear_fault", 32'(fault), 32'd0);
        chk("t6_clear_code", 32'(fault_code), 32'd0);
        repeat (2) cyc(G, R, G, R, 0);
        cyc(G, G, G, R, 0);
        cyc(G, G, G, R, 1);
        chk("t6_clr_blocked", 32'(fault), 32'd1);
        chk("t6_code_kept", 32'(fault_code), 32'd2);
        repeat (3) cyc(R, R, R, R, 0);
        do_reset();
        chk("t6_reset_fault", 32'(fault), 32'd0);
        chk("t6_reset_count", 32'(fault_count), 32'd0);

        // Randomized legal controller traffic with occasional glitches and clears.
        cyc(R, R, R, R, 0);
        rand_run(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
